// File: rtl/spi_command_receiver_if.sv
// spi_command_receiver_if: SPI pins plus the downstream address/register strobe bus.
interface spi_command_receiver_if;
  logic       sclk;
  logic       mosi;
  logic       csN;
  logic       miso;
  logic [7:0] readData;
  logic [7:0] dataBus;
  logic       addrSel;
  logic       en;
  logic       rdWr;
  logic       frameErr;
  modport slave (input sclk, mosi, csN, readData, output miso, dataBus, addrSel, en, rdWr, frameErr);
  modport master (output sclk, mosi, csN, readData, input miso, dataBus, addrSel, en, rdWr, frameErr);
endinterface

// File: rtl/spi_command_receiver.sv
// spi_command_receiver: SPI mode-0 slave decoding a command/address byte followed by
// data bytes, emitting one-cycle en strobes to a downstream register stage.
module spi_command_receiver #(
  parameter int SYNC_STAGES   = 2,
  parameter int CLK_RATIO_MIN = 16
) (
  input logic                    clk,
  input logic                    rst,
  spi_command_receiver_if.slave  bus
);
  if (CLK_RATIO_MIN < 2 * SYNC_STAGES + 8) begin : g_ratio_guard
    $error("CLK_RATIO_MIN too small to fit synchroniser latency and the strobe sequence");
  end
  typedef enum logic [2:0] {IDLE, CMD, ADDR_OUT, DATA, DATA_OUT} state_t;
  state_t                       state_q;
  logic [SYNC_STAGES-1:0][2:0]  sync_q;
  logic                         sclk_prev_q, csn_prev_q;
  logic [2:0]                   cnt_q;
  logic [1:0]                   ph_q;
  logic [7:0]                   rx_q, tx_q, byte_q, data_q;
  logic                         addr_sel_q, en_q, rd_wr_q, ferr_q;
  logic                         sclk_s, mosi_s, csn_s;
  logic                         sclk_rise, sclk_fall, csn_rise, csn_fall, wrap;
  logic [7:0]                   rx_d;
  assign sclk_s    = sync_q[SYNC_STAGES-1][0];
  assign mosi_s    = sync_q[SYNC_STAGES-1][1];
  assign csn_s     = sync_q[SYNC_STAGES-1][2];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign rx_d      = {rx_q[6:0], mosi_s};
  assign wrap      = sclk_rise && cnt_q == 3'd7;
  assign bus.miso     = tx_q[7];
  assign bus.dataBus  = data_q;
  assign bus.addrSel  = addr_sel_q;
  assign bus.en       = en_q;
  assign bus.rdWr     = rd_wr_q;
  assign bus.frameErr = ferr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
      cnt_q       <= 3'd0;
      ph_q        <= 2'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      byte_q      <= 8'h00;
      data_q      <= 8'h00;
      addr_sel_q  <= 1'b1;
      en_q        <= 1'b0;
      rd_wr_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q[0] <= {bus.csN, bus.mosi, bus.sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
      ferr_q      <= 1'b0;
      if (csn_rise) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
        ph_q    <= 2'd0;
        rx_q    <= 8'h00;
        tx_q    <= 8'h00;
        en_q    <= 1'b0;
        ferr_q  <= cnt_q != 3'd0;
      end else if (state_q == IDLE) begin
        if (csn_fall) begin
          state_q <= CMD;
          cnt_q   <= 3'd0;
        end
      end else begin
        if (sclk_rise) begin
          rx_q  <= rx_d;
          cnt_q <= cnt_q + 3'd1;
        end
        // The falling edge right after a byte boundary would discard a freshly loaded MSB before the master samples it.
        if (sclk_fall && cnt_q != 3'd0) tx_q <= {tx_q[6:0], 1'b0};
        case (state_q)
          CMD: if (wrap) begin
            rd_wr_q <= rx_d[7];
            byte_q  <= rx_d;
            ph_q    <= 2'd0;
            state_q <= ADDR_OUT;
          end
          DATA: if (wrap) begin
            byte_q <= rx_d;
            if (rd_wr_q) tx_q <= bus.readData;
            else state_q <= DATA_OUT;
          end
          ADDR_OUT, DATA_OUT: begin
            ph_q <= ph_q + 2'd1;
            en_q <= ph_q == 2'd1;
            if (ph_q == 2'd0) begin
              data_q     <= state_q == ADDR_OUT ? {4'b0000, byte_q[3:0]} : byte_q;
              addr_sel_q <= state_q == DATA_OUT;
            end
            if (ph_q == 2'd2) begin
              ph_q    <= 2'd0;
              state_q <= DATA;
              if (state_q == ADDR_OUT && rd_wr_q) tx_q <= bus.readData;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/spi_command_receiver.md
SPI_COMMAND_RECEIVER -- requirements
Module: spi_command_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flops in each synchroniser on sclk, mosi and csN.
REQ-002 Parameter CLK_RATIO_MIN, default 16, documented minimum clk/sclk frequency ratio; the block is not required to function below it.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 mosi  input  1  SPI serial data in, MSB first.
REQ-007 csN  input  1  SPI chip select, active-low, frames one transaction.
REQ-008 miso  output  1  SPI serial data out, MSB first.
REQ-009 readData  input  8  register value returned for read commands.
REQ-010 dataBus  output  8  byte presented to the downstream address/register stage.
REQ-011 addrSel  output  1  0 = dataBus carries an address, 1 = dataBus carries data.
REQ-012 en  output  1  one-cycle strobe; downstream captures dataBus/addrSel on its rising edge.
REQ-013 rdWr  output  1  command direction of the current frame, 1 = read, 0 = write.
REQ-014 frameErr  output  1  one-cycle pulse when a frame ends on a partial byte.

Function
REQ-015 sclk, mosi and csN SHALL each pass through SYNC_STAGES flip-flops; edge detection SHALL use the synchronised sclk only.
REQ-016 The FSM SHALL have states IDLE, CMD, ADDR_OUT, DATA, DATA_OUT.
REQ-017 IDLE -> CMD on the synchronised csN falling edge; bit counter cleared to 0.
REQ-018 In CMD and DATA, each synchronised sclk rising edge SHALL shift synchronised mosi into rxShift (LSB in) and increment a 3-bit bit counter, wrapping 7 -> 0.
REQ-019 When the counter wraps in CMD: rdWr <= rxByte[7]; state -> ADDR_OUT.
REQ-020 ADDR_OUT: cycle 1 dataBus <= {4'b0000, rxByte[3:0]}, addrSel <= 0; cycle 2 en = 1; cycle 3 en = 0, state -> DATA.
REQ-021 dataBus and addrSel SHALL be stable from one cycle before en rises until at least one cycle after en falls.
REQ-022 Read frame: txShift SHALL load readData in the cycle en falls in ADDR_OUT; miso SHALL present txShift[7] immediately and shift left on each synchronised sclk falling edge.
REQ-023 Write frame: miso SHALL be 0 throughout.
REQ-024 When the counter wraps in DATA with rdWr = 0: state -> DATA_OUT; same 3-cycle sequence as REQ-020 with dataBus <= rxByte, addrSel <= 1; then back to DATA.
REQ-025 Further complete bytes in the same frame SHALL each repeat REQ-024 (burst to same address); in read frames further bytes SHALL reload readData after each byte and produce no en.
REQ-026 Synchronised csN rising edge in any state SHALL force state -> IDLE next cycle, clear counters and shift registers, drive miso 0, and force en 0, aborting any pending strobe.
REQ-027 frameErr SHALL pulse for exactly one cycle if csN rises while the bit counter is nonzero.
REQ-028 An sclk edge detected while in ADDR_OUT or DATA_OUT SHALL still be shifted and counted, not lost.
REQ-029 sclk edges while csN is high SHALL be ignored.

Reset
REQ-030 While rst is high at a clk edge: state IDLE, dataBus 8'h00, addrSel 1, en 0, rdWr 0, miso 0, frameErr 0, counters, synchronisers and shift registers 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no en and no frameErr; after release the block SHALL wait for a fresh csN falling edge.

Verification
REQ-032 Write frame 8'h05, 8'hA7, sclk = clk/16 -> en pulse with addrSel 0, dataBus 8'h05; then en pulse with addrSel 1, dataBus 8'hA7; rdWr 0; miso 0.
REQ-033 Read frame 8'h83, readData 8'h3C -> one en pulse with addrSel 0, dataBus 8'h03; rdWr 1; miso shifts 0,0,1,1,1,1,0,0 during byte 2; no data-phase en.
REQ-034 Burst write 8'h02, 8'h11, 8'h22 -> three en pulses: (0, 8'h02), (1, 8'h11), (1, 8'h22).
REQ-035 csN raised after 5 bits of byte 2 -> frameErr one-cycle pulse, no data en, state IDLE; a following full write frame completes correctly.
REQ-036 rst asserted for 1 cycle mid-command byte -> all outputs at reset values, no en; a following frame 8'h0F, 8'h55 yields (0, 8'h0F), (1, 8'h55).
